pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Sequences the 32-bit program counter for the fetch stage: issues instruction-memory requests,
//  waits on the memory handshake, honours pipeline stalls and picks the next PC from
//  exception/JR/jump/branch/sequential sources. Owns the architectural PC register; sits
//  between the decode/branch logic and instruction memory.
// PARAMETERS
//  N_BITS      32            PC/address width
//  RESET_PC    32'h0040_0000 PC loaded on reset
//  EXC_VECTOR  32'h8000_0180 PC loaded on exception
// PORTS
//  clk              in   1       rising-edge clock
//  reset            in   1       synchronous, active-low reset
//  imem_req_o       out  1       fetch request to instruction memory
//  imem_addr_o      out  N_BITS  fetch address (= pc_o while imem_req_o=1)
//  imem_ready_i     in   1       memory returns instruction this cycle
//  instr_valid_o    out  1       fetched instruction valid for decode (one pulse per instruction)
//  stall_i          in   1       downstream cannot accept an instruction
//  branch_taken_i   in   1       conditional branch resolved taken
//  branch_target_i  in   N_BITS  branch target
//  jump_i           in   1       J/JAL
//  jump_target_i    in   N_BITS  jump target
//  jr_i             in   1       JR/JALR
//  jr_target_i      in   N_BITS  register target
//  exception_i      in   1       exception request
//  pc_o             out  N_BITS  current PC
//  pc_plus4_o       out  N_BITS  pc_o + 4 (link value)
//  addr_err_o       out  1       1-cycle pulse: selected target had bits[1:0]!=0
// BEHAVIOUR
//  - All state updates on posedge clk; reset sampled only on posedge clk.
//  - Reset (reset==0): pc_o=RESET_PC, state=IDLE, imem_req_o=0, instr_valid_o=0, addr_err_o=0,
//    pending redirect cleared. Reset overrides every other input, including mid-fetch.
//  - pc_plus4_o = pc_o + 4, modulo 2^N_BITS (0xFFFF_FFFC -> 0x0000_0000); combinational.
//  - Next-PC priority: exception_i > jr_i > jump_i > branch_taken_i > pc_o+4.
//  - Selected target bits[1:0] forced to 00; addr_err_o pulses the cycle the PC is loaded
//    from a misaligned non-sequential target. EXC_VECTOR and pc+4 never flag.
//  - FSM states:
//    IDLE : imem_req_o=0. Next cycle -> FETCH (first request exactly 1 cycle after reset release).
//    FETCH: imem_req_o=1, imem_addr_o=pc_o.
//           ready=0: stay; any redirect this cycle is latched into pending (higher priority
//           replaces a lower pending one; equal/lower ignored).
//           ready=1,stall=0: instr_valid_o=1; pc_o<=redirect-this-cycle, else pending, else pc+4;
//           stay FETCH (back-to-back fetch, throughput 1/cycle when ready held high).
//           ready=1,stall=1: instr_valid_o=1 held; -> HOLD.
//           If a pending redirect existed when ready=1, the returned instruction is discarded
//           (instr_valid_o=0), pc_o<=pending target, pending cleared, stay FETCH.
//    HOLD : imem_req_o=0, instr_valid_o=1, pc_o frozen. stall=0 -> pc_o<=next-PC (priority
//           above, pending included), pending cleared, -> FETCH. Redirects while stall=1 latch
//           into pending.
//  - exception_i in any non-reset state: pc_o<=EXC_VECTOR next cycle, pending cleared,
//    instr_valid_o=0 that cycle, -> FETCH (outstanding fetch abandoned).
//  - Latency: redirect seen with ready=1,stall=0 -> new imem_addr_o on the following cycle.
// TESTING
//  1. reset=0 two cycles, release -> pc_o=0x0040_0000, req=0 one cycle, then req=1 addr=0x0040_0000.
//  2. ready held 1, no redirects, 4 cycles -> addrs 0x0040_0000/04/08/0C, instr_valid_o every cycle.
//  3. ready=1, branch_taken_i with target 0x0040_0100 and jump_i 0x0040_0200 same cycle
//     -> next addr 0x0040_0200 (jump wins).
//  4. ready=0 for 3 cycles, jr_i target 0x0040_0043 in cycle 1, then ready=1 -> instr discarded,
//     pc_o=0x0040_0040, addr_err_o pulse.
//  5. ready=1,stall=1 for 2 cycles -> HOLD, pc_o frozen, req=0; stall=0 -> pc advances by 4.
//  6. pc_o=0xFFFF_FFFC, ready=1 -> pc_o wraps to 0; exception_i during HOLD -> pc_o=0x8000_0180;
//     reset=0 mid-fetch -> pc_o=0x0040_0000 next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: issues instruction-memory requests, honours
// stalls, and picks the next PC from exception/JR/jump/branch/sequential sources.
module pc_sequencer #(
    parameter int unsigned       N_BITS     = 32,
    parameter logic [N_BITS-1:0] RESET_PC   = N_BITS'(32'h0040_0000),
    parameter logic [N_BITS-1:0] EXC_VECTOR = N_BITS'(32'h8000_0180)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_o,
    output logic [N_BITS-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    output logic              instr_valid_o,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [N_BITS-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [N_BITS-1:0] jump_target_i,
    input  logic              jr_i,
    input  logic [N_BITS-1:0] jr_target_i,
    input  logic              exception_i,
    output logic [N_BITS-1:0] pc_o,
    output logic [N_BITS-1:0] pc_plus4_o,
    output logic              addr_err_o
);
    localparam int unsigned       PRIO_W    = 2;
    localparam logic [PRIO_W-1:0] PRIO_NONE = 2'd0;
    localparam logic [PRIO_W-1:0] PRIO_BR   = 2'd1;
    localparam logic [PRIO_W-1:0] PRIO_J    = 2'd2;
    localparam logic [PRIO_W-1:0] PRIO_JR   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] pc_q, pc_d;
    logic [N_BITS-1:0] pend_tgt_q, pend_tgt_d;
    logic [PRIO_W-1:0] pend_prio_q, pend_prio_d;
    logic              addr_err_q, addr_err_d;

    logic [PRIO_W-1:0] cur_prio, sel_prio;
    logic [N_BITS-1:0] cur_tgt, sel_tgt, sel_aligned, pc_inc;
    logic              sel_misaligned;

    // Redirect requested this cycle, by source priority
    always_comb begin
        cur_prio = PRIO_NONE;
        cur_tgt  = '0;
        if (jr_i) begin
            cur_prio = PRIO_JR;
            cur_tgt  = jr_target_i;
        end else if (jump_i) begin
            cur_prio = PRIO_J;
            cur_tgt  = jump_target_i;
        end else if (branch_taken_i) begin
            cur_prio = PRIO_BR;
            cur_tgt  = branch_target_i;
        end
    end

    // A new redirect only displaces the pending one if strictly higher priority
    always_comb begin
        if (cur_prio > pend_prio_q) begin
            sel_prio = cur_prio;
            sel_tgt  = cur_tgt;
        end else begin
            sel_prio = pend_prio_q;
            sel_tgt  = pend_tgt_q;
        end
    end

    assign sel_aligned    = {sel_tgt[N_BITS-1:2], 2'b00};
    assign sel_misaligned = |sel_tgt[1:0];
    assign pc_inc         = pc_q + N_BITS'(4);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            pend_prio_q <= PRIO_NONE;
            pend_tgt_q  <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_prio_q <= pend_prio_d;
            pend_tgt_q  <= pend_tgt_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Next-state and next-PC selection
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_prio_d = pend_prio_q;
        pend_tgt_d  = pend_tgt_q;
        addr_err_d  = 1'b0;
        if (exception_i) begin
            state_d     = S_FETCH;
            pc_d        = EXC_VECTOR;
            pend_prio_d = PRIO_NONE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (!imem_ready_i) begin
                        pend_prio_d = sel_prio;
                        pend_tgt_d  = sel_tgt;
                    end else if (pend_prio_q != PRIO_NONE || !stall_i) begin
                        if (sel_prio != PRIO_NONE) begin
                            pc_d       = sel_aligned;
                            addr_err_d = sel_misaligned;
                        end else begin
                            pc_d = pc_inc;
                        end
                        pend_prio_d = PRIO_NONE;
                    end else begin
                        pend_prio_d = sel_prio;
                        pend_tgt_d  = sel_tgt;
                        state_d     = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (stall_i) begin
                        pend_prio_d = sel_prio;
                        pend_tgt_d  = sel_tgt;
                    end else begin
                        if (sel_prio != PRIO_NONE) begin
                            pc_d       = sel_aligned;
                            addr_err_d = sel_misaligned;
                        end else begin
                            pc_d = pc_inc;
                        end
                        pend_prio_d = PRIO_NONE;
                        state_d     = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake outputs; a fetch returned while a redirect is pending is dropped
    always_comb begin
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req_o    = 1'b1;
                instr_valid_o = imem_ready_i && (pend_prio_q == PRIO_NONE) && !exception_i;
            end
            S_HOLD:  instr_valid_o = !exception_i;
            default: ;
        endcase
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_inc;
    assign addr_err_o  = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written redirect corner cases,
// then randomized cycles checked against a behavioural model.
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_PC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset, imem_req_o, imem_ready_i, instr_valid_o, stall_i;
    logic        branch_taken_i, jump_i, jr_i, exception_i, addr_err_o;
    logic [31:0] imem_addr_o, branch_target_i, jump_target_i, jr_target_i, pc_o, pc_plus4_o;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ready_i   (imem_ready_i),
        .instr_valid_o  (instr_valid_o),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .jr_i           (jr_i),
        .jr_target_i    (jr_target_i),
        .exception_i    (exception_i),
        .pc_o           (pc_o),
        .pc_plus4_o     (pc_plus4_o),
        .addr_err_o     (addr_err_o)
    );

    typedef struct {
        logic        rst_n, rdy, stl, exc, jr, jmp, br;
        logic [31:0] jrt, jt, bt;
        logic        chk, e_req, e_valid, e_err;
        logic [31:0] e_pc;
    } vec_t;

    int errors = 0;
    int checks = 0;
    bit use_model = 1'b0;

    // Behavioural model: fetch outstanding / instruction held / best pending redirect
    logic        m_out = 1'b0, m_held = 1'b0, m_err = 1'b0;
    logic [31:0] m_pc = '0, m_ptgt = '0;
    int          m_pprio = 0;

    function automatic vec_t mk(input logic rst_n, rdy, stl, exc, input logic [2:0] red,
                                input logic [31:0] t_hi, t_br, input logic chk, e_req,
                                e_valid, input logic [31:0] e_pc, input logic e_err);
        vec_t v;
        v.rst_n = rst_n; v.rdy = rdy; v.stl = stl; v.exc = exc;
        v.jr = red[2]; v.jmp = red[1]; v.br = red[0];
        v.jrt = t_hi; v.jt = t_hi; v.bt = t_br;
        v.chk = chk; v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic take(input logic [31:0] tgt);
        m_pc    = tgt & ~32'h3;
        m_err   = (tgt[1:0] != 2'b00);
        m_pprio = 0;
    endtask

    task automatic model_update(input vec_t v);
        int          p, cp;
        logic [31:0] t, ct;
        p  = v.jr ? 3 : v.jmp ? 2 : v.br ? 1 : 0;
        t  = v.jr ? v.jrt : v.jmp ? v.jt : v.bt;
        cp = (p > m_pprio) ? p : m_pprio;
        ct = (p > m_pprio) ? t : m_ptgt;
        m_err = 1'b0;
        if (!v.rst_n) begin
            m_pc = RST_PC; m_out = 1'b0; m_held = 1'b0; m_pprio = 0;
        end else if (v.exc) begin
            m_pc = EXC_PC; m_out = 1'b1; m_held = 1'b0; m_pprio = 0;
        end else if (!m_out && !m_held) begin
            m_out = 1'b1;
        end else if (m_out) begin
            if (!v.rdy) begin
                m_pprio = cp; m_ptgt = ct;
            end else if (m_pprio != 0 || !v.stl) begin
                if (cp != 0) take(ct);
                else m_pc = m_pc + 32'd4;
            end else begin
                m_pprio = cp; m_ptgt = ct; m_out = 1'b0; m_held = 1'b1;
            end
        end else if (v.stl) begin
            m_pprio = cp; m_ptgt = ct;
        end else begin
            if (cp != 0) take(ct);
            else m_pc = m_pc + 32'd4;
            m_pprio = 0; m_held = 1'b0; m_out = 1'b1;
        end
    endtask

    task automatic step(input vec_t v);
        logic m_valid;
        @(negedge clk);
        reset = v.rst_n; imem_ready_i = v.rdy; stall_i = v.stl; exception_i = v.exc;
        jr_i = v.jr; jr_target_i = v.jrt; jump_i = v.jmp; jump_target_i = v.jt;
        branch_taken_i = v.br; branch_target_i = v.bt;
        #1;
        if (v.chk) begin
            check("req", 32'(imem_req_o), 32'(v.e_req));
            check("valid", 32'(instr_valid_o), 32'(v.e_valid));
            check("pc", pc_o, v.e_pc);
            check("pc_plus4", pc_plus4_o, v.e_pc + 32'd4);
            check("addr_err", 32'(addr_err_o), 32'(v.e_err));
            if (v.e_req) check("addr", imem_addr_o, v.e_pc);
        end
        if (use_model) begin
            m_valid = !v.exc && ((m_out && v.rdy && m_pprio == 0) || m_held);
            check("m_req", 32'(imem_req_o), 32'(m_out));
            check("m_valid", 32'(instr_valid_o), 32'(m_valid));
            check("m_pc", pc_o, m_pc);
            check("m_pc_plus4", pc_plus4_o, m_pc + 32'd4);
            check("m_addr_err", 32'(addr_err_o), 32'(m_err));
            if (m_out) check("m_addr", imem_addr_o, m_pc);
        end
        model_update(v);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        reset = 1'b0; imem_ready_i = 1'b0; stall_i = 1'b0; exception_i = 1'b0;
        jr_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b0;
        jr_target_i = '0; jump_target_i = '0; branch_target_i = '0;

        // reset, release, first request one cycle later
        tbl.push_back(mk(0,0,0,0,3'b000,0,0, 0, 0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0, 1, 0,0,RST_PC,0));
        tbl.push_back(mk(1,0,0,0,3'b000,0,0, 1, 0,0,RST_PC,0));
        // back-to-back sequential fetches
        tbl.push_back(mk(1,1,0,0,3'b000,0,0, 1, 1,1,32'h0040_0000,0));
        tbl.push_back(mk(1,1,0,0,3'b000,0,0, 1, 1,1,32'h0040_0004,0));
        tbl.push_back(mk(1,1,0,0,3'b000,0,0, 1, 1,1,32'h0040_0008,0));
        tbl.push_back(mk(1,1,0,0,3'b000,0,0, 1, 1,1,32'h0040_000C,0));
        // jump beats branch in the same cycle
        tbl.push_back(mk(1,1,0,0,3'b011,32'h0040_0200,32'h0040_0100, 1, 1,1,32'h0040_0010,0));
        // misaligned JR latched while memory busy, returned instruction discarded
        tbl.push_back(mk(1,0,0,0,3'b100,32'h0040_0043,0, 1, 1,0,32'h0040_0200,0));
        tbl.push_back(mk(1,0,0,0,3'b000,0,0, 1, 1,0,32'h0040_0200,0));
        tbl.push_back(mk(1,0,0,0,3'b000,0,0, 1, 1,0,32'h0040_0200,0));
        tbl.push_back(mk(1,1,0,0,3'b000,0,0, 1, 1,0,32'h0040_0200,0));
        tbl.push_back(mk(1,0,0,0,3'b000,0,0, 1, 1,0,32'h0040_0040,1));
        tbl.push_back(mk(1,0,0,0,3'b000,0,0, 1, 1,0,32'h0040_0040,0));
        // stall into hold, pc frozen, release advances by 4
        tbl.push_back(mk(1,1,1,0,3'b000,0,0, 1, 1,1,32'h0040_0040,0));
        tbl.push_back(mk(1,1,1,0,3'b000,0,0, 1, 0,1,32'h0040_0040,0));
        tbl.push_back(mk(1,0,0,0,3'b000,0,0, 1, 0,1,32'h0040_0040,0));
        tbl.push_back(mk(1,0,0,0,3'b000,0,0, 1, 1,0,32'h0040_0044,0));
        // wrap at top of address space, exception in hold, reset mid-fetch
        tbl.push_back(mk(1,1,0,0,3'b010,32'hFFFF_FFFC,0, 1, 1,1,32'h0040_0044,0));
        tbl.push_back(mk(1,1,0,0,3'b000,0,0, 1, 1,1,32'hFFFF_FFFC,0));
        tbl.push_back(mk(1,1,1,0,3'b000,0,0, 1, 1,1,32'h0000_0000,0));
        tbl.push_back(mk(1,0,1,1,3'b000,0,0, 1, 0,0,32'h0000_0000,0));
        tbl.push_back(mk(1,0,0,0,3'b000,0,0, 1, 1,0,EXC_PC,0));
        tbl.push_back(mk(0,1,0,0,3'b000,0,0, 1, 1,1,EXC_PC,0));
        tbl.push_back(mk(1,1,0,0,3'b000,0,0, 1, 0,0,RST_PC,0));
        tbl.push_back(mk(1,1,0,0,3'b000,0,0, 1, 1,1,RST_PC,0));
        foreach (tbl[i]) step(tbl[i]);

        // hold: higher-priority JR replaces pending branch, lower jump ignored
        step(mk(1,1,1,0,3'b001,0,32'h0040_0101, 1, 1,1,32'h0040_0004,0));
        step(mk(1,0,1,0,3'b100,32'h0040_0300,0, 1, 0,1,32'h0040_0004,0));
        step(mk(1,0,1,0,3'b010,32'h0040_0500,0, 1, 0,1,32'h0040_0004,0));
        step(mk(1,0,0,0,3'b000,0,0, 1, 0,1,32'h0040_0004,0));
        // equal-priority redirect while busy keeps the first one
        step(mk(1,0,0,0,3'b001,0,32'h0040_0600, 1, 1,0,32'h0040_0300,0));
        step(mk(1,0,0,0,3'b001,0,32'h0040_0702, 1, 1,0,32'h0040_0300,0));
        step(mk(1,1,0,0,3'b000,0,0, 1, 1,0,32'h0040_0300,0));
        step(mk(1,0,0,0,3'b000,0,0, 1, 1,0,32'h0040_0600,0));

        // randomized traffic against the model
        step(mk(0,0,0,0,3'b000,0,0, 0, 0,0,32'h0,0));
        use_model = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            v = mk(1,0,0,0,3'b000,0,0, 0, 0,0,32'h0,0);
            v.rst_n = ($urandom_range(99) >= 2);
            v.rdy   = ($urandom_range(99) < 60);
            v.stl   = ($urandom_range(99) < 30);
            v.exc   = ($urandom_range(99) < 3);
            v.jr    = ($urandom_range(99) < 10);
            v.jmp   = ($urandom_range(99) < 10);
            v.br    = ($urandom_range(99) < 15);
            v.jrt   = $urandom;
            v.jt    = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : $urandom;
            v.bt    = $urandom;
            step(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
